// File: rtl/slave_mem_arbiter_pkg.sv
// Shared types for the two-port slave memory arbiter: FSM state encoding and owner index.
package slave_mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

  // 0 = requester 0, 1 = requester 1
  typedef logic owner_t;

endpackage

// File: rtl/slave_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the slave memory.
interface slave_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req0, req1;
  logic                  wr0, wr1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  grant0, grant1;
  logic                  done0, done1;
  logic                  err0, err1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  mem_wen, mem_ren;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_rvalid,
    output grant0, grant1, done0, done1, err0, err1, rdata0, rdata1,
           mem_wen, mem_ren, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_rvalid,
    input  grant0, grant1, done0, done1, err0, err1, rdata0, rdata1,
           mem_wen, mem_ren, mem_addr, mem_wdata
  );
endinterface

// File: rtl/slave_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; the pointer names the winner when both request.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] pick_c
);

  logic ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= ~ptr_q;
    end
  end

  always_comb begin
    pick_c = 2'b00;
    case (req)
      2'b01:   pick_c = 2'b01;
      2'b10:   pick_c = 2'b10;
      2'b11:   pick_c = ptr_q ? 2'b10 : 2'b01;
      default: pick_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/slave_mem_arbiter.sv
// Shares one slave memory between two requesters: round-robin pick, registered
// command, strobe sequencing, read capture with bounded rvalid wait, done/err pulse.
module slave_mem_arbiter
  import slave_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic              clk,
  input logic              rstn,
  slave_mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  cmd_wr_q, cmd_wr_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  grant0_q, grant0_d, grant1_q, grant1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic                  wen_q, wen_d, ren_q, ren_d;
  logic [1:0]            pick_c;
  logic                  advance_c;

  rr_arb2 u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     ({bus.req1, bus.req0}),
    .advance (advance_c),
    .pick_c  (pick_c)
  );

  // All outputs and command state are registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cnt_q       <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cnt_q       <= cnt_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      grant0_q    <= grant0_d;
      grant1_q    <= grant1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cnt_d       = cnt_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    grant0_d    = grant0_q;
    grant1_d    = grant1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    advance_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|pick_c) begin
          owner_d     = pick_c[1];
          cmd_wr_d    = pick_c[1] ? bus.wr1    : bus.wr0;
          cmd_addr_d  = pick_c[1] ? bus.addr1  : bus.addr0;
          cmd_wdata_d = pick_c[1] ? bus.wdata1 : bus.wdata0;
          cnt_d       = '0;
          grant0_d    = pick_c[0];
          grant1_d    = pick_c[1];
          wen_d       = pick_c[1] ? bus.wr1  : bus.wr0;
          ren_d       = pick_c[1] ? !bus.wr1 : !bus.wr0;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (cmd_wr_q) begin
          done0_d = !owner_q;
          done1_d = owner_q;
          state_d = RESP;
        end else if (bus.mem_rvalid) begin
          if (owner_q) rdata1_d = bus.mem_rdata;
          else         rdata0_d = bus.mem_rdata;
          done0_d = !owner_q;
          done1_d = owner_q;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          // No rvalid in the whole window: return zero data with an error.
          if (owner_q) rdata1_d = '0;
          else         rdata0_d = '0;
          done0_d = !owner_q;
          done1_d = owner_q;
          err0_d  = !owner_q;
          err1_d  = owner_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          ren_d = 1'b1;
        end
      end

      RESP: begin
        grant0_d  = 1'b0;
        grant1_d  = 1'b0;
        advance_c = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign bus.grant0    = grant0_q;
  assign bus.grant1    = grant1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_ren   = ren_q;
  assign bus.mem_addr  = cmd_addr_q;
  assign bus.mem_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_slave_mem_arbiter.sv
// Scoreboard bench for slave_mem_arbiter: a transaction-level model predicts service
// order, data, error and completion cycle; a monitor checks each done pulse.
module tb_slave_mem_arbiter;

  localparam int AW      = 12;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  slave_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  slave_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    bit          owner;
    bit          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] data;
    bit          err;
    int          done_cyc;
    int          ren;
    int          wen;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          m_ptr;
  logic [DW-1:0] ref_mem [4096];
  logic [DW-1:0] exp_rd [2];
  bit          in_resp;

  // Slave memory environment: preloaded pattern, write on wen, rvalid after a delay.
  logic [DW-1:0] env_mem [4096];
  bit            env_init = 1'b0;
  int            rv_delay;
  bit            rv_stuck;
  int            ren_seen = 0;
  logic          rv_noise = 1'b0;
  logic [DW-1:0] junk = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 4096; i++) env_mem[i] <= DW'(i * 37 + 5);
      env_init <= 1'b1;
    end else if (bus.mem_wen) begin
      env_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  always @(posedge clk) ren_seen <= bus.mem_ren ? ren_seen + 1 : 0;

  always @(negedge clk) begin
    rv_noise <= 1'($urandom);
    junk     <= DW'($urandom);
  end

  always_comb begin
    bus.mem_rvalid = bus.mem_ren ? (!rv_stuck && ren_seen >= rv_delay) : rv_noise;
    bus.mem_rdata  = (bus.mem_ren && bus.mem_rvalid) ? env_mem[bus.mem_addr] : junk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant0"}, 32'(bus.grant0), 0);
    chk({tag, "_grant1"}, 32'(bus.grant1), 0);
    chk({tag, "_done0"},  32'(bus.done0), 0);
    chk({tag, "_done1"},  32'(bus.done1), 0);
    chk({tag, "_err0"},   32'(bus.err0), 0);
    chk({tag, "_err1"},   32'(bus.err1), 0);
    chk({tag, "_wen"},    32'(bus.mem_wen), 0);
    chk({tag, "_ren"},    32'(bus.mem_ren), 0);
    chk({tag, "_maddr"},  32'(bus.mem_addr), 0);
    chk({tag, "_mwdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, "_rdata0"}, 32'(bus.rdata0), 0);
    chk({tag, "_rdata1"}, 32'(bus.rdata1), 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    in_resp = 1'b0;
  endtask

  // Predicts the whole exchange from the rules, pushes expectations, then plays the requesters.
  task automatic issue(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input int dly, input bit stuck);
    bit   who [2];
    int   n, base, prev, kk, budget;
    bit   pend0, pend1;
    exp_t e;
    rv_delay = dly;
    rv_stuck = stuck;
    base = cyc + (in_resp ? 1 : 0);
    n = 0;
    if (r0 && r1) begin who[0] = m_ptr; who[1] = !m_ptr; n = 2; end
    else if (r0)  begin who[0] = 1'b0; n = 1; end
    else if (r1)  begin who[0] = 1'b1; n = 1; end
    prev = 0;
    for (int i = 0; i < n; i++) begin
      e.owner = who[i];
      e.rd    = who[i] ? !w1 : !w0;
      e.addr  = who[i] ? a1 : a0;
      e.wdata = who[i] ? d1 : d0;
      kk      = !e.rd ? 0 : (stuck ? TIMEOUT : dly);
      e.done_cyc = (i == 0) ? base + 2 + kk : prev + 3 + kk;
      prev    = e.done_cyc;
      e.err   = e.rd && stuck;
      e.ren   = e.rd ? kk + 1 : 0;
      e.wen   = e.rd ? 0 : 1;
      if (e.rd) e.data = stuck ? '0 : ref_mem[e.addr];
      else begin
        e.data = '0;
        ref_mem[e.addr] = e.wdata;
      end
      m_ptr = !m_ptr;
      sb.push_back(e);
    end
    bus.req0 = r0; bus.wr0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.wr1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    pend0 = r0; pend1 = r1; budget = 0;
    while ((pend0 || pend1) && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
      if (bus.done0) begin pend0 = 1'b0; bus.req0 = 1'b0; end
      if (bus.done1) begin pend1 = 1'b0; bus.req1 = 1'b0; end
    end
    if (pend0 || pend1) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no done after %0d cycles expected done within 200", budget);
      finish_run();
    end
    in_resp = 1'b1;
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop on every done pulse.
  int wen_cnt = 0;
  int ren_cnt = 0;
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rstn) begin
      wen_cnt = 0;
      ren_cnt = 0;
    end else begin
      chk("grant_excl", 32'(bus.grant0 & bus.grant1), 0);
      chk("strobe_excl", 32'(bus.mem_wen & bus.mem_ren), 0);
      chk("err_wo_done", 32'((bus.err0 & !bus.done0) | (bus.err1 & !bus.done1)), 0);
      if (bus.mem_wen || bus.mem_ren)
        chk("strobe_wo_grant", 32'(bus.grant0 | bus.grant1), 1);
      if (bus.mem_wen) wen_cnt++;
      if (bus.mem_ren) ren_cnt++;
      if ((bus.grant0 || bus.grant1) && sb.size() > 0) begin
        chk("grant_owner", 32'(sb[0].owner ? bus.grant1 : bus.grant0), 1);
        chk("mem_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
        if (!sb[0].rd) chk("mem_wdata", 32'(bus.mem_wdata), 32'(sb[0].wdata));
      end
      if (bus.done0 || bus.done1) begin
        chk("done_excl", 32'(bus.done0 & bus.done1), 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done0=%0b done1=%0b expected no done", bus.done0, bus.done1);
        end else begin
          e = sb.pop_front();
          chk("done_owner", 32'(bus.done1), 32'(e.owner));
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("err", 32'(e.owner ? bus.err1 : bus.err0), 32'(e.err));
          chk("wen_cycles", 32'(wen_cnt), 32'(e.wen));
          chk("ren_cycles", 32'(ren_cnt), 32'(e.ren));
          if (e.rd) exp_rd[e.owner] = e.data;
          chk("rdata0", 32'(bus.rdata0), 32'(exp_rd[0]));
          chk("rdata1", 32'(bus.rdata1), 32'(exp_rd[1]));
        end
        wen_cnt = 0;
        ren_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    finish_run();
  end

  initial begin
    bit r0, r1, w0, w1, stuck;
    logic [AW-1:0] a0, a1;
    int dly;
    rstn = 1'b0;
    bus.req0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    rv_delay = 0; rv_stuck = 0; m_ptr = 0; in_resp = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = DW'(i * 37 + 5);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;
    idle_cycles(1);

    // Requester 0 write then read back.
    issue(1, 1, 12'h010, 8'hA5, 0, 0, '0, '0, 0, 0);
    issue(1, 0, 12'h010, 8'h00, 0, 0, '0, '0, 0, 0);
    idle_cycles(1);

    // Contention: strict alternation 0,1,0,1.
    issue(1, 0, 12'h020, '0, 1, 0, 12'h030, '0, 0, 0);
    issue(1, 0, 12'h021, '0, 1, 0, 12'h031, '0, 1, 0);
    idle_cycles(2);

    // Delayed rvalid and full timeout.
    issue(1, 0, 12'h044, '0, 0, 0, '0, '0, 3, 0);
    issue(0, 0, '0, '0, 1, 0, 12'h055, '0, 0, 1);
    issue(0, 0, '0, '0, 1, 0, 12'h056, '0, 1, 0);

    // Back-to-back writes at the address extremes, then readback.
    issue(0, 0, '0, '0, 1, 1, 12'hFFF, 8'h3C, 0, 0);
    issue(0, 0, '0, '0, 1, 1, 12'h000, 8'hC3, 0, 0);
    issue(0, 0, '0, '0, 1, 0, 12'hFFF, '0, 0, 0);
    issue(0, 0, '0, '0, 1, 0, 12'h000, '0, 2, 0);

    // Reset in the middle of a read's ACCESS phase.
    idle_cycles(1);
    rv_stuck = 1'b1;
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 12'h123;
    @(posedge clk);
    #1;
    chk("pre_reset_grant0", 32'(bus.grant0), 1);
    #3 rstn = 1'b0;
    bus.req0 = 1'b0;
    #1;
    check_zero("midreset");
    sb.delete();
    m_ptr = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("inreset");
    rstn = 1'b1;
    idle_cycles(1);
    issue(1, 0, 12'h010, '0, 1, 0, 12'hFFF, '0, 0, 0);
    issue(0, 0, '0, '0, 1, 0, 12'h200, '0, 1, 0);

    // Randomized mix of single and contended transfers.
    for (int it = 0; it < 60; it++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      a0 = $urandom_range(0, 1) ? AW'($urandom) : AW'($urandom_range(0, 7));
      a1 = $urandom_range(0, 1) ? AW'($urandom) : AW'($urandom_range(0, 7));
      dly = $urandom_range(0, 3);
      stuck = ($urandom_range(0, 9) == 0);
      issue(r0, w0, a0, DW'($urandom), r1, w1, a1, DW'($urandom), dly, stuck);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end

    idle_cycles(3);
    chk("sb_drained", 32'(sb.size()), 0);
    finish_run();
  end

endmodule

// File: doc/slave_mem_arbiter.md
# slave_mem_arbiter

Two-port controller that shares one slave memory (ADDR_WIDTH address, DATA_WIDTH data, combinational read with `rvalid` qualifier) between two bus-side requesters. It arbitrates round-robin, registers the winning command, and sequences the memory's `wen`/`ren` strobes. It captures read data, with a bounded wait on `rvalid`, and returns a one-cycle completion pulse to the winner. It sits between the slave port logic of the system bus and the memory array.

## Interface
- ADDR_WIDTH, 12, memory address width
- DATA_WIDTH, 8, memory data width
- TIMEOUT, 16, max ACCESS cycles a read waits for `mem_rvalid` before erroring (≥1)
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, asynchronous assert, active-low
- req0 / req1  in  1  requester n wants a transfer; held high until its done pulse
- wr0 / wr1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_WIDTH  transfer address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- grant0 / grant1  out  1  requester n owns the memory (ACCESS and RESP)
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  one-cycle pulse with done on read timeout
- rdata0 / rdata1  out  DATA_WIDTH  read data, valid with done, held until that requester's next read completes
- mem_wen, mem_ren  out  1  memory strobes
- mem_addr  out  ADDR_WIDTH, mem_wdata  out  DATA_WIDTH  registered command to memory
- mem_rdata  in  DATA_WIDTH, mem_rvalid  in  1  memory read return

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req, pick winner, latch wr/addr/wdata into command regs, set owner, go ACCESS; else stay.
- Arbitration: single requester wins unconditionally. Both requesting: requester named by priority pointer wins. Pointer moves to the other requester on every RESP exit.
- ACCESS write: mem_wen=1 for exactly one cycle; go RESP. `mem_rvalid` ignored.
- ACCESS read: mem_ren=1 each ACCESS cycle. On first cycle with mem_rvalid=1, capture mem_rdata into owner's rdata reg, go RESP. Wait counter increments each cycle without rvalid. After TIMEOUT cycles without rvalid: owner's rdata ← 0, flag error, go RESP.
- RESP: done (and err if flagged) pulses for owner; strobes low; go IDLE.
- mem_addr/mem_wdata driven from command regs; never change during ACCESS.
- Requester must drop req (or present a new command) on the edge after done. A req still high in IDLE is a new transfer.
- Reset values: all outputs 0, rdata0/1 = 0, state IDLE, pointer = requester 0, counter 0.
- Reset mid-transfer: immediate abort, no done or err, no further strobes; an in-flight write may or may not have been committed.

## Timing
- Cycle 0 (IDLE): req sampled. Cycle 1 (ACCESS): grant, strobe. Cycle 2 (RESP): done.
- Minimum 3 cycles per transfer, 3-cycle back-to-back cadence; throughput 1 transfer / 3 cycles.
- Read with rvalid delayed k cycles: done at cycle 2+k.
- Read timeout: done+err at cycle 2+TIMEOUT.
- grant is mutually exclusive; mem_wen and mem_ren never high together.
- No combinational path from any req/wr/addr input to any output.

## Structure
- Package `slave_mem_arb_pkg`: state enum (IDLE, ACCESS, RESP) and owner index type (1 bit).
- One sub-module, `rr_arb2`: 2-input round-robin picker with pointer register. Inputs req[1:0] and advance; outputs one-hot pick.
- Top holds the FSM, command regs, wait counter ($clog2(TIMEOUT+1) bits), and rdata regs.

## Test plan
- Write then read, requester 0 only: write 0xA5 @0x010, read @0x010 → mem_wen one cycle at cycle 1; read done0 at cycle 2 with rdata0=0xA5; grant1 never high.
- Simultaneous req0, req1 reads from reset → req0 served first (done0 cycle 2), req1 next (done1 cycle 5); repeated contention alternates strictly 0,1,0,1.
- mem_rvalid low 3 cycles on read → mem_ren held 4 cycles, mem_addr stable, done at cycle 5, err=0.
- mem_rvalid stuck low, TIMEOUT=16 → done+err at cycle 18, rdata of owner = 0x00, FSM back in IDLE.
- rstn pulled low during ACCESS of a read → all outputs 0 asynchronously, no done; after release, pointer=0 and a fresh req1 completes normally.
- Back-to-back writes req1 @0xFFF then @0x000 (address extremes) → done1 every 3 cycles; readback returns both values; rdata0 untouched.
